// File: rtl/dds_pkg.sv
// Shared DDS constants and the quarter-wave sine table generator.
// The table is built with fixed-point integer math, so it elaborates without real-valued functions.
package dds_pkg;

  localparam int PHASE_W = 14;
  localparam int ADDR_W  = 8;
  localparam int AMP_W   = 8;
  localparam int VOL_W   = 8;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam longint FX_ONE     = 64'sd1073741824;
  localparam longint HALF_PI_FX = 64'sd1686629713;

  // round(peak * sin(pi/2 * (i+0.5) / 2^ADDR_W)) using a Q30 Taylor series
  function automatic logic [AMP_W-2:0] sine_q_entry(input int i);
    longint x;
    longint term;
    longint acc;
    longint peak;
    longint r;
    x    = (HALF_PI_FX * longint'(2 * i + 1)) / longint'(2 ** (ADDR_W + 1));
    term = x;
    acc  = x;
    for (int k = 1; k <= 10; k++) begin
      term = (term * x) / FX_ONE;
      term = (term * x) / FX_ONE;
      term = -term / longint'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    peak = longint'(2 ** (AMP_W - 1) - 1);
    r    = (peak * acc + FX_ONE / 64'sd2) / FX_ONE;
    return (AMP_W-1)'(r);
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine magnitude ROM with a registered read port.
module sine_quarter_rom
  import dds_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [AMP_W-2:0]  data
);

  logic [AMP_W-2:0] rom_tbl [2**ADDR_W];
  logic [AMP_W-2:0] data_d;
  logic [AMP_W-2:0] data_q;

  for (genvar gi = 0; gi < 2**ADDR_W; gi++) begin : g_rom
    assign rom_tbl[gi] = sine_q_entry(gi);
  end

  always_comb begin
    data_d = rom_tbl[addr];
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/phase_to_sine.sv
// Phase word to signed/offset-binary sine sample: mirror, ROM lookup, negate and volume scale.
// Three registered stages; the valid strobe rides alongside the data.
module phase_to_sine
  import dds_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               phase_valid,
  input  logic [VOL_W-1:0]   volume,
  output logic [AMP_W-1:0]   amp_s,
  output logic [AMP_W-1:0]   amp_u,
  output logic               amp_valid
);

  localparam int PROD_W = AMP_W + VOL_W + 1;
  localparam logic [AMP_W-1:0] MSB_MASK = {1'b1, {(AMP_W-1){1'b0}}};

  logic [1:0]        quad;
  logic [ADDR_W-1:0] a_field;
  logic              unused_phase_lsbs;

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              neg1_d, neg1_q, v1_d, v1_q;
  logic              neg2_d, neg2_q, v2_d, v2_q;
  logic [AMP_W-2:0]  mag;

  logic signed [AMP_W-1:0]  s_val;
  logic signed [PROD_W-1:0] s_ext, v_ext;
  logic [AMP_W-1:0]         scaled;
  logic [AMP_W-1:0]         amp_s_d, amp_s_q, amp_u_d, amp_u_q;
  logic                     amp_valid_d, amp_valid_q;

  assign quad              = phase_in[PHASE_W-1 -: 2];
  assign a_field           = phase_in[PHASE_W-3 -: ADDR_W];
  assign unused_phase_lsbs = ^phase_in[PHASE_W-ADDR_W-3:0];

  // Odd quadrants run the table backwards; the upper half-cycle is negated later
  always_comb begin
    addr_d = a_field;
    case (quad)
      Q1, Q3:  addr_d = ~a_field;
      Q0, Q2:  addr_d = a_field;
      default: addr_d = a_field;
    endcase
    neg1_d = quad[1] & phase_valid;
    v1_d   = phase_valid;
    neg2_d = neg1_q;
    v2_d   = v1_q;
  end

  sine_quarter_rom u_rom (
    .clk  (clk),
    .addr (addr_q),
    .data (mag)
  );

  // Product cannot overflow because volume < 2^VOL_W; the cast keeps the floor-shifted slice
  always_comb begin
    s_val  = neg2_q ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    s_ext  = PROD_W'(s_val);
    v_ext  = PROD_W'($signed({1'b0, volume}));
    scaled = AMP_W'((s_ext * v_ext) >>> VOL_W);
    if (v2_q) begin
      amp_s_d = scaled;
      amp_u_d = scaled ^ MSB_MASK;
    end else begin
      amp_s_d = amp_s_q;
      amp_u_d = amp_u_q;
    end
    amp_valid_d = v2_q;
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    if (rst) begin
      neg1_q      <= 1'b0;
      v1_q        <= 1'b0;
      neg2_q      <= 1'b0;
      v2_q        <= 1'b0;
      amp_s_q     <= {AMP_W{1'b0}};
      amp_u_q     <= MSB_MASK;
      amp_valid_q <= 1'b0;
    end else begin
      neg1_q      <= neg1_d;
      v1_q        <= v1_d;
      neg2_q      <= neg2_d;
      v2_q        <= v2_d;
      amp_s_q     <= amp_s_d;
      amp_u_q     <= amp_u_d;
      amp_valid_q <= amp_valid_d;
    end
  end

  assign amp_s     = amp_s_q;
  assign amp_u     = amp_u_q;
  assign amp_valid = amp_valid_q;

endmodule

// File: tb/tb_phase_to_sine.sv
// Self-checking bench for phase_to_sine: spec vector table, streaming sweep against a
// real-valued sine model, sign symmetry, bubbles and mid-operation reset.
module tb_phase_to_sine;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] phase_in;
  logic        phase_valid;
  logic [7:0]  volume;
  logic [7:0]  amp_s;
  logic [7:0]  amp_u;
  logic        amp_valid;

  phase_to_sine dut (
    .clk         (clk),
    .rst         (rst),
    .phase_in    (phase_in),
    .phase_valid (phase_valid),
    .volume      (volume),
    .amp_s       (amp_s),
    .amp_u       (amp_u),
    .amp_valid   (amp_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] phase;
    int          exp_s;
    logic [7:0]  exp_u;
    int          due;
    bit          tag;
  } exp_t;

  typedef struct {
    logic [13:0] phase;
    logic [7:0]  vol;
    int          exp_s;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   sweep_got[256];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_s(input logic [13:0] p, input logic [7:0] vol);
    real x;
    real ax;
    int  mag;
    int  s;
    x   = $sin(2.0 * 3.14159265358979 * (real'(p[13:4]) + 0.5) / 1024.0);
    ax  = (x < 0.0) ? -x : x;
    mag = $rtoi(ax * 127.0 + 0.5);
    s   = (x < 0.0) ? -mag : mag;
    return $rtoi($floor(real'(s * int'(vol)) / 256.0));
  endfunction

  task automatic push_exp(input logic [13:0] p, input int es, input bit tag);
    exp_t e;
    logic [7:0] u;
    u = 8'(es + 128);
    e = '{p, es, u, cyc + 3, tag};
    sb.push_back(e);
  endtask

  task automatic drive(input logic r, input logic v, input logic [13:0] p,
                       input logic [7:0] vol, input bit push, input bit tag);
    @(posedge clk);
    #1;
    rst         = r;
    phase_valid = v;
    phase_in    = p;
    volume      = vol;
    if (push) push_exp(p, model_s(p, vol), tag);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic [7:0] es;
    forever begin
      @(negedge clk);
      if (amp_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: amp_valid=1 amp_s=%0d with nothing pending (cycle %0d)",
                   $signed(amp_s), cyc);
        end else begin
          e  = sb.pop_front();
          es = e.exp_s[7:0];
          if (amp_s !== es || amp_u !== e.exp_u || cyc != e.due) begin
            errors++;
            $display("FAIL sample phase=%h: got s=%0d u=%h at cycle %0d, expected s=%0d u=%h at cycle %0d",
                     e.phase, $signed(amp_s), amp_u, cyc, e.exp_s, e.exp_u, e.due);
          end
          if (e.tag) sweep_got[e.phase[13:6]] = int'($signed(amp_s));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        e = sb.pop_front();
        $display("FAIL missing_valid phase=%h: amp_valid=%b at cycle %0d, expected 1 at cycle %0d",
                 e.phase, amp_valid, cyc, e.due);
      end
    end
  endtask

  initial begin
    int sum;
    vecs[0] = '{14'h0000, 8'd255, 0};
    vecs[1] = '{14'h1000, 8'd255, 126};
    vecs[2] = '{14'h2000, 8'd255, 0};
    vecs[3] = '{14'h3000, 8'd255, -127};
    vecs[4] = '{14'h1000, 8'd128, 63};
    vecs[5] = '{14'h3000, 8'd128, -64};
    vecs[6] = '{14'h1000, 8'd0, 0};
    vecs[7] = '{14'h0800, 8'd255, 89};

    rst         = 1'b1;
    phase_valid = 1'b1;
    phase_in    = 14'h1000;
    volume      = 8'd255;
    fork
      monitor();
    join_none

    // Reset held with valid asserted: outputs must stay at rest
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_amp_s", 32'(amp_s), 32'h00);
      check("reset_amp_u", 32'(amp_u), 32'h80);
      check("reset_amp_valid", 32'(amp_valid), 32'h0);
    end

    // First post-reset sample, timed exactly by the scoreboard
    drive(1'b0, 1'b1, 14'h1000, 8'd255, 1'b1, 1'b0);
    repeat (4) drive(1'b0, 1'b0, 14'h1000, 8'd255, 1'b0, 1'b0);

    // Spec vector table, one isolated sample each
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, vecs[i].phase, vecs[i].vol, 1'b0, 1'b0);
      push_exp(vecs[i].phase, vecs[i].exp_s, 1'b0);
      repeat (4) drive(1'b0, 1'b0, vecs[i].phase, vecs[i].vol, 1'b0, 1'b0);
      if (vecs[i].vol == 8'd0) begin
        check("vol0_amp_s", 32'(amp_s), 32'h00);
        check("vol0_amp_u", 32'(amp_u), 32'h80);
      end
    end

    // Streaming sweep with wrap-around, back-to-back valids
    for (int i = 0; i < 264; i++)
      drive(1'b0, 1'b1, 14'(i * 64), 8'd255, 1'b1, i < 256);
    repeat (5) drive(1'b0, 1'b0, 14'h0000, 8'd255, 1'b0, 1'b0);

    for (int i = 0; i < 128; i++) begin
      sum = sweep_got[i] + sweep_got[i + 128];
      checks++;
      if (sum > 1 || sum < -1) begin
        errors++;
        $display("FAIL symmetry idx=%0d: amp=%0d and mirrored amp=%0d, required sum within 1",
                 i, sweep_got[i], sweep_got[i + 128]);
      end
    end

    // Second sweep at a different volume and coarser step
    for (int i = 0; i < 64; i++)
      drive(1'b0, 1'b1, 14'(i * 256 + 16), 8'd100, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b0, 14'h0000, 8'd100, 1'b0, 1'b0);

    // Bubble pattern 1,0,1,1 with reset while sample 3 sits in stage 2
    drive(1'b0, 1'b1, 14'h1000, 8'd255, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 14'h1000, 8'd255, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 14'h3000, 8'd255, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 14'h0800, 8'd255, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 14'h0000, 8'd255, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 14'h0000, 8'd255, 1'b0, 1'b0);
    @(negedge clk);
    check("midrst_amp_s", 32'(amp_s), 32'h00);
    check("midrst_amp_u", 32'(amp_u), 32'h80);
    check("midrst_amp_valid", 32'(amp_valid), 32'h0);
    repeat (5) drive(1'b0, 1'b0, 14'h0000, 8'd255, 1'b0, 1'b0);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
